// File: rtl/seg_dynamic_drv_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared constants, types and helpers for the six-digit seven-segment
// display driver (seg_dynamic_drv) and its BCD converter (bcd_8421).
//   DIGITS / DEC_MAX      : display width and largest displayable value
//   SEG_*                 : active-low segment codes, bit 7 = dp, [6:0]=gfedcba
//   bcd_digit_t/bcd_word_t: one BCD nibble / six packed nibbles (digit 0 LSB)
//   conv_state_t          : converter FSM state encoding
//   seg_decode()          : BCD nibble -> segment code
//   bcd_adjust()          : add-3 correction step of double dabble
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam int          DIGITS     = 6;
  localparam int          BIN_W      = 20;
  localparam int          BCD_W      = 4 * DIGITS;
  localparam logic [19:0] DEC_MAX    = 20'd999_999;
  localparam logic [4:0]  LAST_SHIFT = 5'(BIN_W - 1);

  localparam logic [7:0] SEG_0       = 8'hC0;
  localparam logic [7:0] SEG_1       = 8'hF9;
  localparam logic [7:0] SEG_2       = 8'hA4;
  localparam logic [7:0] SEG_3       = 8'hB0;
  localparam logic [7:0] SEG_4       = 8'h99;
  localparam logic [7:0] SEG_5       = 8'h92;
  localparam logic [7:0] SEG_6       = 8'h82;
  localparam logic [7:0] SEG_7       = 8'hF8;
  localparam logic [7:0] SEG_8       = 8'h80;
  localparam logic [7:0] SEG_9       = 8'h90;
  localparam logic [7:0] SEG_MINUS   = 8'hBF;
  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  localparam logic [7:0] SEG_DP_MASK = 8'h7F;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [DIGITS-1:0] bcd_word_t;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_t;

  function automatic logic [7:0] seg_decode(input bcd_digit_t d);
    logic [7:0] code;
    case (d)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Any nibble >= 5 gets +3 so that the following left shift carries
  // correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_dynamic_drv_bcd_8421.sv
// ---------------------------------------------------------------------------
// bcd_8421
// Iterative binary-to-BCD converter (shift-add-3 / double dabble), one bit
// per clock, 20 iterations.
//   sys_clk  in   system clock
//   sys_rst  in   asynchronous active-high reset
//   start    in   one-cycle pulse: capture bin and begin a conversion
//   bin      in   20-bit unsigned value (caller keeps it <= 999_999)
//   done     out  one-cycle pulse, bcd is valid while done is high
//   bcd      out  six BCD nibbles, digit 0 in bcd[3:0]
//
// Protocol: start is a fire-and-forget pulse (no ready); bin is sampled on
// the start edge only. A start during a conversion restarts it. done is
// high for exactly one cycle, the cycle after the last iteration, and bcd
// holds its value until the next start.
// ---------------------------------------------------------------------------
module bcd_8421
  import seg_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_t      state_q, state_d;
  logic [4:0]       shift_cnt_q;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= CONV_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      CONV_IDLE:  if (start) state_d = CONV_SHIFT;
      CONV_SHIFT: begin
        if (start)                           state_d = CONV_SHIFT;
        else if (shift_cnt_q == LAST_SHIFT)  state_d = CONV_DONE;
      end
      CONV_DONE:  state_d = start ? CONV_SHIFT : CONV_IDLE;
      default:    state_d = CONV_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    done = (state_q == CONV_DONE);
    bcd  = bcd_q;
  end

  assign bcd_adj = bcd_adjust(bcd_q);

  // Datapath: {bcd, bin} acts as one 44-bit shift register; the binary
  // MSB enters the BCD side after the add-3 correction.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bin_q       <= '0;
      bcd_q       <= '0;
      shift_cnt_q <= '0;
    end else if (start) begin
      bin_q       <= bin;
      bcd_q       <= '0;
      shift_cnt_q <= '0;
    end else if (state_q == CONV_SHIFT) begin
      bcd_q       <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_q       <= {bin_q[BIN_W-2:0], 1'b0};
      shift_cnt_q <= shift_cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/seg_dynamic_drv.sv
// ---------------------------------------------------------------------------
// seg_dynamic_drv
// Six-digit multiplexed common-anode seven-segment driver. Samples a
// binary value once per frame, converts it to BCD with bcd_8421, buffers
// the result atomically and scans the digits.
//   CNT_MAX  param  per-digit dwell minus one, in clocks (>= 24)
//   sys_clk  in     system clock
//   sys_rst  in     asynchronous active-high reset
//   data     in     20-bit unsigned value (clamped to 999_999)
//   point    in     decimal-point mask, point[i] lights the dp of digit i
//   sign     in     1 = show a minus
//   seg_en   in     1 = display on, 0 = all digits dark
//   sel      out    one-hot digit select, active-high (registered)
//   seg      out    active-low segments, seg[7]=dp (registered)
// Build option: define SEG_LZ_BLANK_EN for leading-zero blanking with a
// floating minus sign; otherwise all digits are shown and the minus sits
// on digit 5.
// ---------------------------------------------------------------------------
module seg_dynamic_drv
  import seg_pkg::*;
#(
  parameter logic [15:0] CNT_MAX = 16'd49_999
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [BIN_W-1:0]  data,
  input  logic [DIGITS-1:0] point,
  input  logic              sign,
  input  logic              seg_en,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg
);

  localparam logic [2:0] LAST_DIG = 3'(DIGITS - 1);

  // Scan counters
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  dig_idx_q, dig_idx_d;
  logic        first_q;
  logic        dwell_end;
  logic        frame_start;

  // Frame sample registers and converter start pulse
  logic [BIN_W-1:0]  hold_data_q, hold_data_d;
  logic [DIGITS-1:0] hold_point_q;
  logic              hold_sign_q;
  logic              start_q;

  // Display buffer, written only when a conversion completes
  bcd_word_t         buf_digits_q;
  logic [DIGITS-1:0] buf_point_q;
  logic              buf_sign_q;

  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;

  logic [7:0]        digit_code [DIGITS];
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;

  // ---------------- scan timing ----------------
  always_comb begin
    dwell_end = (cnt_q == CNT_MAX);
    cnt_d     = dwell_end ? 16'd0 : cnt_q + 16'd1;
    dig_idx_d = dig_idx_q;
    if (dwell_end) dig_idx_d = (dig_idx_q == LAST_DIG) ? 3'd0 : dig_idx_q + 3'd1;
    // first_q makes the cycle after reset release a frame start so the
    // buffer is populated during the very first digit-0 dwell.
    frame_start = first_q | (dwell_end & (dig_idx_q == LAST_DIG));
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q     <= '0;
      dig_idx_q <= '0;
      first_q   <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      dig_idx_q <= dig_idx_d;
      first_q   <= 1'b0;
    end
  end

  // ---------------- frame sampling ----------------
  assign hold_data_d = (data > DEC_MAX) ? DEC_MAX : data;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold_data_q  <= '0;
      hold_point_q <= '0;
      hold_sign_q  <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      start_q <= frame_start;
      if (frame_start) begin
        hold_data_q  <= hold_data_d;
        hold_point_q <= point;
        hold_sign_q  <= sign;
      end
    end
  end

  bcd_8421 u_bcd (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (start_q),
    .bin     (hold_data_q),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  // Digits, dp mask and sign move into the buffer together so the scan
  // never mixes two frames.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      buf_digits_q <= '0;
      buf_point_q  <= '0;
      buf_sign_q   <= 1'b0;
    end else if (conv_done) begin
      buf_digits_q <= conv_bcd;
      buf_point_q  <= hold_point_q;
      buf_sign_q   <= hold_sign_q;
    end
  end

  // ---------------- digit codes ----------------
`ifdef SEG_LZ_BLANK_EN
  logic [DIGITS-1:0] shown;
  logic [DIGITS-1:0] minus_here;

  // Walk from the leftmost digit: a digit is blanked while everything so
  // far is zero and no dp has been seen at or left of it.
  always_comb begin : lz_blank
    logic zero_left;
    logic dp_left;
    shown     = '0;
    zero_left = 1'b1;
    dp_left   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_left = zero_left & (buf_digits_q[i] == 4'd0);
      dp_left   = dp_left | buf_point_q[i];
      shown[i]  = (i == 0) | ~zero_left | dp_left;
    end
  end

  // Blanks are contiguous from the left, so the first blank left of the
  // most significant shown digit is the blank whose right neighbour shows.
  always_comb begin : sign_place
    minus_here = '0;
    for (int i = 1; i < DIGITS; i++) begin
      minus_here[i] = buf_sign_q & ~shown[i] & shown[i-1];
    end
  end
`endif

  always_comb begin : digit_codes
    for (int i = 0; i < DIGITS; i++) begin
`ifdef SEG_LZ_BLANK_EN
      if (shown[i])           digit_code[i] = seg_decode(buf_digits_q[i]);
      else if (minus_here[i]) digit_code[i] = SEG_MINUS;
      else                    digit_code[i] = SEG_BLANK;
`else
      if (buf_sign_q && (i == DIGITS - 1)) digit_code[i] = SEG_MINUS;
      else                                 digit_code[i] = seg_decode(buf_digits_q[i]);
`endif
      if (buf_point_q[i]) digit_code[i] = digit_code[i] & SEG_DP_MASK;
    end
  end

  // ---------------- output registers ----------------
  always_comb begin
    sel_d = '0;
    seg_d = SEG_BLANK;
    if (seg_en) begin
      sel_d = DIGITS'(1) << dig_idx_q;
      seg_d = digit_code[dig_idx_q];
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel_q <= '0;
      seg_q <= SEG_BLANK;
    end else begin
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_dynamic_drv.sv
// ---------------------------------------------------------------------------
// tb_seg_dynamic_drv
// Directed plus randomized bench for seg_dynamic_drv with CNT_MAX=49.
// Expected segment codes come from a decimal arithmetic model of the
// display rules; both build variants (SEG_LZ_BLANK_EN defined or not) are
// modelled.
// ---------------------------------------------------------------------------
module tb_seg_dynamic_drv;

  localparam logic [15:0] CNT_MAX = 16'd49;
  localparam int          DWELL   = 50;

  // ---------------- clock / reset ----------------
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [19:0] data    = '0;
  logic [5:0]  point   = '0;
  logic        sign    = 1'b0;
  logic        seg_en  = 1'b1;
  logic [5:0]  sel;
  logic [7:0]  seg;

  always #5 sys_clk = ~sys_clk;

  seg_dynamic_drv #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .data    (data),
    .point   (point),
    .sign    (sign),
    .seg_en  (seg_en),
    .sel     (sel),
    .seg     (seg)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] num_code(input int unsigned dg);
    case (dg)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Segment code of digit d for a given input set, from decimal arithmetic.
  function automatic logic [7:0] model_code(input int unsigned value, input logic [5:0] pt,
                                            input logic sg, input int d);
    int unsigned v, pow, dg, p;
    int          n_shown;
    logic [7:0]  code;
    v   = (value > 999_999) ? 999_999 : value;
    pow = 1;
    for (int k = 0; k < d; k++) pow = pow * 10;
    dg  = (v / pow) % 10;
`ifdef SEG_LZ_BLANK_EN
    // Shown digits: every significant digit, digit 0, and everything at or
    // right of a lit dp.
    n_shown = 1;
    p = 1;
    for (int k = 1; k < 6; k++) begin
      p = p * 10;
      if (v >= p || pt[k]) n_shown = k + 1;
    end
    if (d < n_shown)             code = num_code(dg);
    else if (sg && d == n_shown) code = 8'hBF;
    else                         code = 8'hFF;
`else
    n_shown = 6;
    code = (sg && d == 5) ? 8'hBF : num_code(dg);
`endif
    if (pt[d]) code = code & 8'h7F;
    return code;
  endfunction

  // ---------------- driver / monitor tasks ----------------
  // Returns at the first negedge where sel has just become digit 0.
  task automatic wait_frame_start();
    logic [5:0] prev;
    int         n;
    n = 0;
    do begin
      prev = sel;
      @(negedge sys_clk);
      n++;
    end while (!(sel == 6'b000001 && prev != 6'b000001) && n < 1000);
    chk("frame_wait", {31'd0, (n < 1000)}, 32'd1);
  endtask

  // Called at a frame-start negedge; checks select, code and dwell of all
  // six digits and returns at the next frame-start negedge.
  task automatic check_frame(input int unsigned v, input logic [5:0] pt, input logic sg);
    for (int d = 0; d < 6; d++) exp_q.push_back(model_code(v, pt, sg, d));
    for (int d = 0; d < 6; d++) begin
      logic [7:0] e;
      logic [5:0] cur;
      int         dwell;
      e     = exp_q.pop_front();
      cur   = sel;
      chk($sformatf("sel_digit%0d", d), {26'd0, sel}, 32'd1 << d);
      dwell = 0;
      while (sel == cur && dwell < 200) begin
        chk($sformatf("seg_digit%0d_v%0d", d, v), {24'd0, seg}, {24'd0, e});
        dwell++;
        @(negedge sys_clk);
      end
      chk($sformatf("dwell_digit%0d", d), dwell, DWELL);
    end
  endtask

  // Apply inputs, confirm they reach digit 0 inside the first dwell after
  // sampling, then check a complete following frame.
  task automatic display_test(input int unsigned v, input logic [5:0] pt, input logic sg);
    data  = v[19:0];
    point = pt;
    sign  = sg;
    wait_frame_start();
    repeat (30) @(negedge sys_clk);
    chk("digit0_update", {24'd0, seg}, {24'd0, model_code(v, pt, sg, 0)});
    wait_frame_start();
    check_frame(v, pt, sg);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned rv;
    logic [5:0]  rp;
    logic        rs;
    int          dwell;

    // Reset held: outputs at reset values.
    #1 sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_sel", {26'd0, sel}, 32'd0);
    chk("rst_seg", {24'd0, seg}, 32'hFF);

    // Release with data=0: digit 0 lit first, 50-cycle dwell.
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("first_sel", {26'd0, sel}, 32'd1);
    chk("first_seg", {24'd0, seg}, 32'hC0);
    dwell = 0;
    while (sel == 6'b000001 && dwell < 200) begin
      dwell++;
      @(negedge sys_clk);
    end
    chk("first_dwell", dwell, DWELL);
    chk("second_sel", {26'd0, sel}, 32'd2);
    wait_frame_start();
    check_frame(0, 6'd0, 1'b0);

    // Directed display patterns.
    display_test(123456, 6'b000100, 1'b0);
    display_test(42, 6'b000000, 1'b1);
    display_test(1_048_575, 6'b000000, 1'b0);
    display_test(5, 6'b000100, 1'b1);

    // seg_en drop and raise mid-dwell (we are at a frame start).
    repeat (30) @(negedge sys_clk);
    seg_en = 1'b0;
    #1;
    chk("en_drop_latency_sel", {26'd0, sel}, 32'd1);
    @(negedge sys_clk);
    chk("en_off_sel", {26'd0, sel}, 32'd0);
    chk("en_off_seg", {24'd0, seg}, 32'hFF);
    repeat (2) @(negedge sys_clk);
    seg_en = 1'b1;
    #1;
    chk("en_rise_latency_sel", {26'd0, sel}, 32'd0);
    @(negedge sys_clk);
    chk("en_on_sel", {26'd0, sel}, 32'd1);
    chk("en_on_seg", {24'd0, seg}, {24'd0, model_code(5, 6'b000100, 1'b1, 0)});

    // Mid-conversion change is ignored until the next frame start.
    display_test(135, 6'd0, 1'b0);
    wait_frame_start();
    data = 20'd777_777;
    repeat (34) @(negedge sys_clk);
    chk("midconv_ignored", {24'd0, seg}, {24'd0, model_code(135, 6'd0, 1'b0, 0)});

    // Reset during a conversion, then recovery with the current data.
    wait_frame_start();
    repeat (8) @(negedge sys_clk);
    data = 20'd654_321;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    chk("async_rst_sel", {26'd0, sel}, 32'd0);
    chk("async_rst_seg", {24'd0, seg}, 32'hFF);
    repeat (3) @(negedge sys_clk);
    chk("rst_hold_sel", {26'd0, sel}, 32'd0);
    chk("rst_hold_seg", {24'd0, seg}, 32'hFF);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rerelease_sel", {26'd0, sel}, 32'd1);
    chk("rerelease_seg", {24'd0, seg}, 32'hC0);
    repeat (4) @(negedge sys_clk);
    chk("rerelease_old_buf", {24'd0, seg}, 32'hC0);
    repeat (25) @(negedge sys_clk);
    chk("rerelease_new_buf", {24'd0, seg}, {24'd0, model_code(654_321, 6'd0, 1'b0, 0)});
    wait_frame_start();
    check_frame(654_321, 6'd0, 1'b0);

    // Randomized patterns, biased toward short values for blanking cases.
    for (int t = 0; t < 8; t++) begin
      rv = $urandom_range(0, 20'hFFFFF) >> $urandom_range(0, 19);
      rp = ($urandom_range(0, 2) == 0) ? (6'd1 << $urandom_range(0, 5)) : 6'd0;
      rs = 1'($urandom_range(0, 1));
      display_test(rv, rp, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
